// File: rtl/gcd_defs.sv
// Definitions shared by the GCD host and the GCD controller/datapath pair.
package gcd_defs;

  localparam int W = 16;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_SEND = 2'd1,
    H_WAIT = 2'd2,
    H_TAKE = 2'd3
  } host_state_e;

  // Operand-register input muxes inside the GCD datapath.
  typedef enum logic [1:0] {
    A_SEL_IN  = 2'd0,
    A_SEL_B   = 2'd1,
    A_SEL_SUB = 2'd2
  } a_sel_e;

  typedef enum logic {
    B_SEL_IN = 1'b0,
    B_SEL_A  = 1'b1
  } b_sel_e;

endpackage

// File: rtl/gcd_host_fifo.sv
// Count-based synchronous FIFO; storage is cleared on reset so the head reads 0 when empty.
module gcd_host_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/gcd_host.sv
// Issues queued operand pairs to the GCD unit one at a time and returns results in order.
module gcd_host #(
  parameter int W       = gcd_defs::W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset_,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [W-1:0] operand_A,
  output logic [W-1:0] operand_B,
  output logic         input_available,
  input  logic         idle,
  input  logic         result_rdy,
  input  logic [W-1:0] result_data,
  output logic         result_taken,
  output logic         busy,
  output logic         err_timeout,
  output logic [15:0]  done_count
);

  import gcd_defs::*;

  localparam int WDW = $clog2(TIMEOUT + 1);

  host_state_e    state;
  logic [WDW-1:0] wdog;
  logic [2*W-1:0] cmd_head;
  logic           cmd_full;
  logic           cmd_empty;
  logic           rsp_full;
  logic           rsp_empty;
  logic           start;
  logic           capture;

  // A job starts only with a free response slot, so the in-flight result always fits.
  assign start     = (state == H_IDLE) && !cmd_empty && idle && !rsp_full;
  assign capture   = (state == H_WAIT) && result_rdy;
  assign cmd_ready = !cmd_full;
  assign rsp_valid = !rsp_empty;
  assign busy      = (state != H_IDLE);

  gcd_host_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_a, cmd_b}),
    .pop       (start),
    .head      (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  gcd_host_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset_    (reset_),
    .push      (capture),
    .push_data (result_data),
    .pop       (rsp_valid && rsp_ready),
    .head      (rsp_data),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state           <= H_IDLE;
      operand_A       <= '0;
      operand_B       <= '0;
      input_available <= 1'b0;
      result_taken    <= 1'b0;
      wdog            <= '0;
      err_timeout     <= 1'b0;
      done_count      <= '0;
    end else begin
      case (state)
        H_IDLE: begin
          if (start) begin
            operand_A       <= cmd_head[2*W-1:W];
            operand_B       <= cmd_head[W-1:0];
            input_available <= 1'b1;
            state           <= H_SEND;
          end
        end
        H_SEND: begin
          input_available <= 1'b0;
          wdog            <= '0;
          state           <= H_WAIT;
        end
        H_WAIT: begin
          // Watchdog only flags a stuck job; the host keeps waiting for it.
          if (wdog != WDW'(TIMEOUT)) wdog <= wdog + WDW'(1);
          if (wdog == WDW'(TIMEOUT - 1)) err_timeout <= 1'b1;
          if (result_rdy) begin
            done_count   <= done_count + 16'd1;
            result_taken <= 1'b1;
            state        <= H_TAKE;
          end
        end
        H_TAKE: begin
          result_taken <= 1'b0;
          state        <= H_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_host.sv
// Bench for gcd_host with a behavioural GCD unit on the far side of the handshakes.
module tb_gcd_host;

  localparam int W       = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic         clk = 1'b0;
  logic         reset_ = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [W-1:0] operand_A;
  logic [W-1:0] operand_B;
  logic         input_available;
  logic         idle;
  logic         result_rdy;
  logic [W-1:0] result_data;
  logic         result_taken;
  logic         busy;
  logic         err_timeout;
  logic [15:0]  done_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gcd_host #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset_          (reset_),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_a           (cmd_a),
    .cmd_b           (cmd_b),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .operand_A       (operand_A),
    .operand_B       (operand_B),
    .input_available (input_available),
    .idle            (idle),
    .result_rdy      (result_rdy),
    .result_data     (result_data),
    .result_taken    (result_taken),
    .busy            (busy),
    .err_timeout     (err_timeout),
    .done_count      (done_count)
  );

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural GCD unit: latches on input_available, answers after a latency, waits for result_taken.
  int           fixed_lat = 3;
  int           g_st;
  int           g_cnt;
  logic [W-1:0] ga, gb;

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      g_st        <= 0;
      g_cnt       <= 0;
      idle        <= 1'b1;
      result_rdy  <= 1'b0;
      result_data <= '0;
    end else begin
      case (g_st)
        0: if (input_available) begin
          ga    <= operand_A;
          gb    <= operand_B;
          g_cnt <= (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
          idle  <= 1'b0;
          g_st  <= 1;
        end
        1: if (g_cnt <= 1) begin
          result_rdy  <= 1'b1;
          result_data <= ref_gcd(ga, gb);
          g_st        <= 2;
        end else begin
          g_cnt <= g_cnt - 1;
        end
        default: if (result_taken) begin
          result_rdy <= 1'b0;
          idle       <= 1'b1;
          g_st       <= 0;
        end
      endcase
    end
  end

  // Monitor sampling on the falling edge.
  int             cyc = 0;
  logic [W-1:0]   got_q[$];
  logic [2*W-1:0] iss_q[$];
  int             ia_rise_q[$];
  int             rt_q[$];
  int             ia_cycles = 0;
  int             rt_cycles = 0;
  logic           ia_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_) begin
      got_q.delete();
      iss_q.delete();
      ia_rise_q.delete();
      rt_q.delete();
      ia_cycles = 0;
      rt_cycles = 0;
      ia_prev   = 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
      if (input_available) ia_cycles++;
      if (input_available && !ia_prev) begin
        iss_q.push_back({operand_A, operand_B});
        ia_rise_q.push_back(cyc);
      end
      if (result_taken) begin
        rt_cycles++;
        rt_q.push_back(cyc);
      end
      ia_prev = input_available;
    end
  end

  // Reference model: command order in, gcd of each accepted pair out.
  logic [W-1:0]   exp_q[$];
  logic [2*W-1:0] cmd_q[$];
  int             exp_done = 0;

  task automatic do_reset();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    reset_    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_ = 1'b1;
    exp_q.delete();
    cmd_q.delete();
    exp_done = 0;
  endtask

  task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input int max_wait,
                          output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      cmd_q.push_back({a, b});
      exp_q.push_back(ref_gcd(a, b));
      exp_done++;
    end
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (got_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    n_cmp++;
    if (got_q.size() < n) begin
      n_bad++;
      $display("FAIL %s_wait got %0d responses, want %0d", name, got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, input_available, result_taken, busy, err_timeout} !== 6'b100000) begin
      n_bad++;
      $display("FAIL reset_async_flags got %b want 100000",
               {cmd_ready, rsp_valid, input_available, result_taken, busy, err_timeout});
    end
    do_reset();
    n_cmp++;
    if ({operand_A, operand_B, rsp_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h/%h/%h want 0", operand_A, operand_B, rsp_data);
    end
    n_cmp++;
    if (done_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_done_count got %0d want 0", done_count);
    end
    n_cmp++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 100", {cmd_ready, rsp_valid, busy});
    end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    fixed_lat = 3;
    rsp_ready = 1'b1;
    push_cmd(16'd36, 16'd15, 0, ok);
    @(posedge clk);
    #1;
    n_cmp++;
    if (input_available !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_issue_k1 got ia=%b busy=%b want 1/1", input_available, busy);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (input_available !== 1'b0) begin
      n_bad++;
      $display("FAIL single_issue_k2 got ia=%b want 0", input_available);
    end
    wait_results(1, 40, "single");
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd3) begin
      n_bad++;
      $display("FAIL single_result got %0d (n=%0d) want 3", got_q.size() ? got_q[0] : 0, got_q.size());
    end
    n_cmp++;
    if (iss_q.size() != 1 || iss_q[0] !== {16'd36, 16'd15}) begin
      n_bad++;
      $display("FAIL single_operands got %h want %h", iss_q.size() ? iss_q[0] : 0, {16'd36, 16'd15});
    end
    n_cmp++;
    if (done_count !== 16'd1 || ia_cycles != 1 || rt_cycles != 1) begin
      n_bad++;
      $display("FAIL single_counts got done=%0d ia=%0d rt=%0d want 1/1/1",
               done_count, ia_cycles, rt_cycles);
    end
  endtask

  task automatic test_stream();
    bit ok;
    bit all_ready;
    logic [W-1:0] g;
    do_reset();
    fixed_lat = 0;
    rsp_ready = 1'b1;
    all_ready = 1'b1;
    push_cmd(16'd180, 16'd30, 0, ok); all_ready &= ok;
    push_cmd(16'd7, 16'd0, 0, ok);    all_ready &= ok;
    push_cmd(16'd0, 16'd9, 0, ok);    all_ready &= ok;
    n_cmp++;
    if (!all_ready) begin
      n_bad++;
      $display("FAIL stream_cmd_ready got 0 want 1");
    end
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          g = W'($urandom_range(1, 50));
          push_cmd(W'(g * W'($urandom_range(0, 100))), W'(g * W'($urandom_range(0, 100))), 200, ok);
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL stream_push got blocked want accepted (cmd %0d)", i);
          end
        end
      end
      begin
        repeat (150) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 2) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_results(exp_q.size(), 400, "stream");
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || iss_q[i] !== cmd_q[i]) begin
        n_bad++;
        $display("FAIL stream_result[%0d] got %0d ops %h want %0d ops %h",
                 i, got_q[i], iss_q[i], exp_q[i], cmd_q[i]);
      end
    end
    n_cmp++;
    if (done_count !== 16'(exp_done) || err_timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_done got %0d err=%b want %0d err=0", done_count, err_timeout, exp_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    fixed_lat = 1;
    rsp_ready = 1'b1;
    push_cmd(16'd12, 16'd18, 0, ok);
    push_cmd(16'd21, 16'd14, 0, ok);
    wait_results(2, 60, "b2b");
    n_cmp++;
    if (rt_q.size() < 1 || ia_rise_q.size() < 2 || ia_rise_q[1] - rt_q[0] != 2) begin
      n_bad++;
      $display("FAIL b2b_gap got %0d want 2",
               (rt_q.size() > 0 && ia_rise_q.size() > 1) ? ia_rise_q[1] - rt_q[0] : -1);
    end
    n_cmp++;
    if (got_q.size() < 2 || got_q[0] !== 16'd6 || got_q[1] !== 16'd7) begin
      n_bad++;
      $display("FAIL b2b_results got %0d,%0d want 6,7",
               got_q.size() > 0 ? got_q[0] : 0, got_q.size() > 1 ? got_q[1] : 0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    fixed_lat = 2;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_cmd(16'd12, 16'd8, 80, ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL bp_push got blocked want accepted (cmd %0d)", i);
      end
    end
    push_cmd(16'd12, 16'd8, 30, ok);
    n_cmp++;
    if (ok) begin
      n_bad++;
      $display("FAIL bp_ninth got accepted want blocked");
    end
    repeat (20) @(posedge clk);
    #1;
    n_cmp++;
    if (iss_q.size() != 4 || done_count !== 16'd4 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_held got issued=%0d done=%0d popped=%0d want 4/4/0",
               iss_q.size(), done_count, got_q.size());
    end
    n_cmp++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_flags got %b want 010", {cmd_ready, rsp_valid, busy});
    end
    rsp_ready = 1'b1;
    wait_results(8, 200, "bp");
    for (int i = 0; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== 16'd4) begin
        n_bad++;
        $display("FAIL bp_result[%0d] got %0d want 4", i, got_q[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int n;
    do_reset();
    fixed_lat = 20;
    rsp_ready = 1'b1;
    push_cmd(16'd65535, 16'd1, 0, ok);
    n = 0;
    while (!input_available && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (i == 7) begin
        n_cmp++;
        if (err_timeout !== 1'b0) begin
          n_bad++;
          $display("FAIL wd_early got %b want 0", err_timeout);
        end
      end
    end
    n_cmp++;
    if (err_timeout !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_set got err=%b busy=%b want 1/1", err_timeout, busy);
    end
    wait_results(1, 60, "wd");
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd1 || err_timeout !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_result got %0d err=%b want 1 err=1", got_q.size() ? got_q[0] : 0, err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    fixed_lat = 20;
    rsp_ready = 1'b1;
    push_cmd(16'd36, 16'd15, 0, ok);
    push_cmd(16'd12, 16'd8, 0, ok);
    push_cmd(16'd7, 16'd0, 0, ok);
    repeat (3) @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, input_available, result_taken, busy, err_timeout} !== 6'b100000 ||
        {operand_A, operand_B, done_count} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs got %b ops %h/%h done %0d want 100000 0/0/0",
               {cmd_ready, rsp_valid, input_available, result_taken, busy, err_timeout},
               operand_A, operand_B, done_count);
    end
    repeat (2) @(negedge clk);
    #1;
    reset_ = 1'b1;
    exp_q.delete();
    cmd_q.delete();
    exp_done  = 0;
    fixed_lat = 3;
    push_cmd(16'd36, 16'd15, 0, ok);
    wait_results(1, 40, "mid");
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 16'd3 || iss_q.size() != 1) begin
      n_bad++;
      $display("FAIL mid_after got n=%0d first=%0d issued=%0d want 1/3/1",
               got_q.size(), got_q.size() ? got_q[0] : 0, iss_q.size());
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    fixed_lat = 2;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    force dut.done_count = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.done_count;
    #1;
    n_cmp++;
    if (done_count !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_preload got %h want ffff", done_count);
    end
    push_cmd(16'd50, 16'd20, 0, ok);
    wait_results(1, 40, "wrap");
    n_cmp++;
    if (done_count !== 16'h0000 || got_q[0] !== 16'd10) begin
      n_bad++;
      $display("FAIL wrap_count got %h result %0d want 0000 result 10", done_count, got_q[0]);
    end
  endtask

  initial begin
    #2 reset_ = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/gcd_host.md
# gcd_host

Synthesizable initiator for the GCD unit's two handshakes; it sits between a streaming client and the GCD controller/datapath pair. Operand pairs are queued in a command FIFO and issued one at a time over the input_available/idle handshake. Results are collected over the result_rdy/result_taken handshake and returned in order through a response FIFO. It replaces the behavioural input and output models in system-level benches.

## Interface
- W, 16, operand/result width
- DEPTH, 4, entries in each FIFO (power of two, ≥2)
- TIMEOUT, 1024, cycles in H_WAIT before err_timeout sets (≥1)
- clk  in  1  clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1  command push handshake
- cmd_a, cmd_b  in  W  operand pair
- rsp_valid / rsp_ready  out / in  1  response pop handshake
- rsp_data  out  W  FIFO head result
- operand_A, operand_B  out  W  to GCD, registered
- input_available  out  1  to GCD, registered
- idle  in  1  from GCD
- result_rdy  in  1  from GCD
- result_data  in  W  from GCD
- result_taken  out  1  to GCD, registered
- busy  out  1  host FSM not in H_IDLE
- err_timeout  out  1  sticky watchdog flag
- done_count  out  16  completed jobs, wraps 0xFFFF→0

## Operation
- **Reset values.** All outputs are 0 except cmd_ready=1. Both FIFOs are empty, FSM is in H_IDLE, storage is zeroed. Reset mid-operation discards queued and in-flight jobs. The GCD shares reset_.
- **Command FIFO** (width 2W):
  - Push on cmd_valid && cmd_ready.
  - cmd_ready = !full. It stays low when full even if a pop occurs in the same cycle (no bypass).
- **Response FIFO:**
  - rsp_valid = !empty. Pop on rsp_valid && rsp_ready.
  - rsp_data holds the head value; it reads 0 when empty after reset.
- **FSM:**
  - H_IDLE → H_SEND when cmd FIFO non-empty && idle && rsp FIFO count < DEPTH (one slot reserved for the single in-flight job). On this edge, load operand_A/B from the head, pop the cmd FIFO, and set input_available.
  - H_SEND lasts exactly 1 cycle with input_available=1. → H_WAIT, clearing input_available and the watchdog.
  - H_WAIT: when result_rdy is sampled 1, push result_data into the rsp FIFO, increment done_count, set result_taken, and go to H_TAKE.
    - The watchdog increments each cycle. When it reaches TIMEOUT, err_timeout sets and stays set until reset.
    - The FSM keeps waiting after a timeout; the job is not dropped.
  - H_TAKE lasts exactly 1 cycle with result_taken=1; result_rdy is ignored in this state. → H_IDLE, clearing result_taken.
- **Single in-flight job.** Results leave in command order.
- **Idle gating.** The GCD raises idle outside WAIT as well, so idle alone never starts a job; it is only qualified in H_IDLE.
- **Arithmetic.** Operands pass unmodified; B=0 and A=0 are legal. done_count and the watchdog are unsigned and wrap silently (the watchdog saturates at TIMEOUT).

## Timing
- **Command to issue.** A command pushed at edge k (empty system) gives input_available=1 from edge k+1 to k+2. The GCD latches operands at edge k+2.
- **Capture.** result_rdy sampled at edge m → result_taken high from m to m+1 → rsp_valid=1 after m. The GCD leaves DONE at m+1.
- **Back-to-back jobs.** The earliest next input_available rises at m+2.
- **Simultaneous push and pop on the cmd FIFO (not full).** Both occur and the count is unchanged.
- **Simultaneous push and pop on the rsp FIFO.** Both occur.

## Structure
- Shared package gcd_defs holds:
  - W
  - host state encoding: H_IDLE=0, H_SEND=1, H_WAIT=2, H_TAKE=3
  - the GCD's A_sel/B_sel encodings, kept beside W for the datapath
- One sub-module, gcd_host_fifo (params WIDTH, DEPTH; count-based full/empty), instantiated twice.
- FSM, watchdog and counters live in gcd_host.

## Test plan
- **Single job.** Push (36,15), rsp_ready=1 → one response 3; done_count=1; input_available and result_taken each high exactly 1 cycle.
- **Ordered stream.** Push (180,30), (7,0), (0,9) back-to-back → responses 30, 7, 9 in order; cmd_ready stays 1.
- **Backpressure.** Hold rsp_ready=0 and offer 9 commands (12,8) → 4 results queued, 4 commands held, 9th blocked (cmd_ready=0), no 5th issue. Release rsp_ready → eight responses of 4.
- **Watchdog.** With TIMEOUT=8, push (65535,1) → err_timeout sets 8 cycles into H_WAIT and stays set; response 1 is still delivered.
- **Reset mid-operation.** Drop reset_ during H_WAIT → all outputs at reset values; both FIFOs empty; a following (36,15) returns 3.
- **Wrap.** Preload done_count=0xFFFF (force) and complete one job → done_count=0.
